// File: rtl/nonce_dispatch.sv
// nonce_dispatch: splits a nonce job across NUM_CORES hashing cores, tracks
// completion, and funnels golden nonces through per-core holds, a round-robin
// arbiter and a result FIFO onto a valid/ready stream.
module nonce_dispatch #(
   parameter int unsigned NUM_CORES  = 4,
   parameter int unsigned CORE_IDX_W = 2,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned CNT_W      = 4
) (
   input  logic                    hash_clk,
   input  logic                    reset_n,
   input  logic                    new_work,
   input  logic [31:0]             nonce_min,
   input  logic [31:0]             nonce_max,
   output logic [NUM_CORES-1:0]    core_start,
   output logic [32*NUM_CORES-1:0] core_nonce_min,
   output logic [32*NUM_CORES-1:0] core_nonce_max,
   input  logic [NUM_CORES-1:0]    core_done,
   input  logic [NUM_CORES-1:0]    core_ticket,
   input  logic [32*NUM_CORES-1:0] core_nonce,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_nonce,
   output logic [CORE_IDX_W-1:0]   out_core,
   output logic                    job_busy,
   output logic                    job_done,
   output logic                    job_error,
   output logic                    overflow,
   output logic [CNT_W-1:0]        fifo_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, SPLIT, START, RUN, DONE} state_t;

   state_t                  state;
   logic [31:0]             lat_min;
   logic [31:0]             lat_max;
   logic [NUM_CORES-1:0]    active;

   logic [32:0]             span;
   logic [32:0]             chunk;
   logic [32:0]             offs;
   logic                    range_err;
   logic [32*NUM_CORES-1:0] split_min;
   logic [32*NUM_CORES-1:0] split_max;
   logic [NUM_CORES-1:0]    split_mask;

   logic [NUM_CORES-1:0]    hold_valid;
   logic [31:0]             hold_nonce [NUM_CORES];
   logic [CORE_IDX_W-1:0]   rr_ptr;
   logic [CORE_IDX_W-1:0]   grant;
   logic [CORE_IDX_W-1:0]   cand;
   logic                    grant_vld;
   logic                    cap_en;

   logic [31:0]             fifo_nonce [FIFO_DEPTH];
   logic [CORE_IDX_W-1:0]   fifo_core  [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic                    fifo_full;
   logic                    push;
   logic                    pop;

   // Per-core range split from the bounds latched at new_work
   always_comb begin
      span       = {1'b0, lat_max} - {1'b0, lat_min} + 33'd1;
      chunk      = span >> CORE_IDX_W;
      range_err  = (lat_max < lat_min);
      offs       = '0;
      split_min  = '0;
      split_max  = '0;
      split_mask = '0;
      if (!range_err) begin
         if (chunk == '0) begin
            split_mask[0]    = 1'b1;
            split_min[31:0]  = lat_min;
            split_max[31:0]  = lat_max;
         end else begin
            split_mask = '1;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
               offs = chunk * 33'(i);
               split_min[32*i +: 32] = lat_min + offs[31:0];
               split_max[32*i +: 32] = lat_min + offs[31:0] + chunk[31:0] - 32'd1;
            end
            // remainder lands on the last core
            split_max[32*(NUM_CORES-1) +: 32] = lat_max;
         end
      end
   end

   // Job FSM; new_work restarts from SPLIT in any state (also the abort path)
   always_ff @(posedge hash_clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         lat_min        <= '0;
         lat_max        <= '0;
         active         <= '0;
         core_start     <= '0;
         core_nonce_min <= '0;
         core_nonce_max <= '0;
         job_done       <= 1'b0;
         job_error      <= 1'b0;
      end else if (new_work) begin
         state      <= SPLIT;
         lat_min    <= nonce_min;
         lat_max    <= nonce_max;
         core_start <= '0;
         job_done   <= 1'b0;
         job_error  <= 1'b0;
      end else begin
         core_start <= '0;
         job_done   <= 1'b0;
         case (state)
            SPLIT: begin
               core_nonce_min <= split_min;
               core_nonce_max <= split_max;
               active         <= split_mask;
               if (range_err) begin
                  job_error <= 1'b1;
                  job_done  <= 1'b1;
                  state     <= DONE;
               end else begin
                  core_start <= split_mask;
                  state      <= START;
               end
            end
            START: state <= RUN;
            RUN: begin
               if (&(core_done | ~active)) begin
                  job_done <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign job_busy = (state == SPLIT) || (state == START) || (state == RUN);

   assign cap_en    = !new_work && (state != SPLIT);
   assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign out_valid = (fifo_count != '0);
   assign pop       = out_valid && out_ready;
   assign push      = grant_vld && !new_work && (!fifo_full || pop);
   assign out_nonce = out_valid ? fifo_nonce[rd_ptr] : '0;
   assign out_core  = out_valid ? fifo_core[rd_ptr] : '0;

   // Round-robin pick among valid holds, searching from rr_ptr upward
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
         cand = rr_ptr + CORE_IDX_W'(k);
         if (!grant_vld && hold_valid[cand]) begin
            grant_vld = 1'b1;
            grant     = cand;
         end
      end
   end

   // Ticket holding registers, arbiter pointer and overflow flag
   always_ff @(posedge hash_clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_valid <= '0;
         rr_ptr     <= '0;
         overflow   <= 1'b0;
         for (int unsigned i = 0; i < NUM_CORES; i++) hold_nonce[i] <= '0;
      end else if (new_work) begin
         hold_valid <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push)
            rr_ptr <= (grant == CORE_IDX_W'(NUM_CORES - 1)) ? '0 : grant + 1'b1;
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            // a hold drained this edge may reload from a same-edge ticket
            if (cap_en && core_ticket[i]) begin
               if (!hold_valid[i] || (push && grant == CORE_IDX_W'(i))) begin
                  hold_valid[i] <= 1'b1;
                  hold_nonce[i] <= core_nonce[32*i +: 32];
               end else begin
                  overflow <= 1'b1;
               end
            end else if (push && grant == CORE_IDX_W'(i)) begin
               hold_valid[i] <= 1'b0;
            end
         end
      end
   end

   // FIFO storage write
   always_ff @(posedge hash_clk) begin
      if (push) begin
         fifo_nonce[wr_ptr] <= hold_nonce[grant];
         fifo_core[wr_ptr]  <= grant;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge hash_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else if (new_work) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            fifo_count <= fifo_count + 1'b1;
         else if (!push && pop)
            fifo_count <= fifo_count - 1'b1;
      end
   end

endmodule
